// File: rtl/bitcnt_pkg.sv
// bitcnt_pkg: shared function codes, request record and operand helpers for the bitcnt prep stage
// Contents: bitcnt_func_e codes, bitcnt_req_t queued record, rev32/rev64, is_word/is_rev/is_illegal.
package bitcnt_pkg;

   // Widest tag the queued record can carry; the top zero-extends its TAG_W tag into it.
   localparam int TAG_W_MAX = 16;

   typedef enum logic [2:0] {
      FN_CLZ   = 3'b000,
      FN_CTZ   = 3'b001,
      FN_PCNT  = 3'b010,
      FN_CLZW  = 3'b100,
      FN_CTZW  = 3'b101,
      FN_PCNTW = 3'b110
   } bitcnt_func_e;

   typedef struct packed {
      logic [63:0]          data;
      logic [2:0]           func;
      logic                 revmode;
      logic                 illegal;
      logic [TAG_W_MAX-1:0] tag;
   } bitcnt_req_t;

   function automatic logic [31:0] rev32(input logic [31:0] x);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = x[31-i];
      return r;
   endfunction

   function automatic logic [63:0] rev64(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[i] = x[63-i];
      return r;
   endfunction

   function automatic logic is_word(input logic [2:0] f);
      return f[2];
   endfunction

   // CLZ and CLZW are counted as trailing zeros of the reversed operand.
   function automatic logic is_rev(input logic [2:0] f);
      return f[1:0] == 2'b00;
   endfunction

   function automatic logic is_illegal(input logic [2:0] f);
      return f[1:0] == 2'b11;
   endfunction

endpackage

// File: rtl/bitcnt_prep_fifo.sv
// bitcnt_prep_fifo: DEPTH-entry synchronous FIFO of bitcnt_req_t records with full/empty/count
// Ports: clock, resetn (async active-low), push_i/din_i write side, pop_i read side,
//        dout_o head entry, full_o, empty_o, count_o entry count.
module bitcnt_prep_fifo
   import bitcnt_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = bitcnt_req_t
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  T                       din_i,
   output T                       dout_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   T              mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push, pop;

   // Pushes at full and pops at empty are dropped so the count never leaves 0..DEPTH.
   assign push    = push_i && !full_o;
   assign pop     = pop_i && !empty_o;
   assign cnt_d   = cnt_q + CW'(push) - CW'(pop);
   assign full_o  = cnt_q == FULL_CNT;
   assign empty_o = cnt_q == '0;
   assign count_o = cnt_q;
   assign dout_o  = mem_q[rd_q];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= wr_q + AW'(1);
         end
         if (pop) rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bitcnt_prep.sv
// bitcnt_prep: operand conditioning and request buffering in front of the bitcnt core
// Ports: clock, resetn (async active-low); in_valid/in_ready/in_data/in_func/in_tag request side;
//        out_valid/out_ready/out_data/out_func/out_revmode/out_illegal/out_tag core side;
//        occupancy = queued entry count.
// Option: BITCNT_PREP_BYPASS_EN lets a request reach the core in the same cycle while the
//         queue is empty and the core is ready; otherwise every request passes through the queue.
module bitcnt_prep
   import bitcnt_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int TAG_W = 4
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [63:0]            in_data,
   input  logic [2:0]             in_func,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [63:0]            out_data,
   output logic [2:0]             out_func,
   output logic                   out_revmode,
   output logic                   out_illegal,
   output logic [TAG_W-1:0]       out_tag,
   output logic [$clog2(DEPTH):0] occupancy
);

   bitcnt_req_t req, head, out_sel, last_q;
   logic [31:0] w;
   logic        push, pop, full, empty;
   logic        unused_tag;

   assign w = in_data[31:0];

   // Word forms place the word in the low half; an all-ones upper half caps CTZW/CLZW at 32.
   always_comb begin
      req         = '0;
      req.func    = in_func;
      req.revmode = is_rev(in_func);
      req.illegal = is_illegal(in_func);
      req.tag     = TAG_W_MAX'(in_tag);
      req.data    = req.illegal     ? 64'h0 :
                    is_word(in_func) ? {in_func[1] ? 32'h0 : 32'hFFFF_FFFF, req.revmode ? rev32(w) : w} :
                    req.revmode     ? rev64(in_data) : in_data;
   end

   bitcnt_prep_fifo #(
      .DEPTH (DEPTH),
      .T     (bitcnt_req_t)
   ) u_fifo (
      .clock   (clock),
      .resetn  (resetn),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (req),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (occupancy)
   );

   assign in_ready = !full;
   assign pop      = !empty && out_ready;

`ifdef BITCNT_PREP_BYPASS_EN
   logic byp;
   // Empty queue and ready core: hand the request straight over instead of queueing it.
   assign byp       = empty && out_ready;
   assign push      = in_valid && in_ready && !byp;
   assign out_valid = !empty || in_valid;
   assign out_sel   = !empty ? head : in_valid ? req : last_q;
`else
   assign push      = in_valid && in_ready;
   assign out_valid = !empty;
   assign out_sel   = empty ? last_q : head;
`endif

   // The queue slot is stale once popped, so the last delivered entry is kept for the idle outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) last_q <= '0;
      else if (out_valid && out_ready) last_q <= out_sel;
   end

   assign out_data    = out_sel.data;
   assign out_func    = out_sel.func;
   assign out_revmode = out_sel.revmode;
   assign out_illegal = out_sel.illegal;
   assign out_tag     = out_sel.tag[TAG_W-1:0];
   assign unused_tag  = ^out_sel.tag;

endmodule

// File: tb/tb_bitcnt_prep.sv
// tb_bitcnt_prep: self-checking bench for bitcnt_prep in its default queued configuration
module tb_bitcnt_prep;

   localparam int DEPTH = 2;
   localparam int TAG_W = 4;

   logic             clock = 1'b0;
   logic             resetn = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [63:0]      in_data = '0;
   logic [2:0]       in_func = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [63:0]      out_data;
   logic [2:0]       out_func;
   logic             out_revmode;
   logic             out_illegal;
   logic [TAG_W-1:0] out_tag;
   logic [1:0]       occupancy;

   int checks = 0;
   int errors = 0;

   bitcnt_prep #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_func     (in_func),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_func    (out_func),
      .out_revmode (out_revmode),
      .out_illegal (out_illegal),
      .out_tag     (out_tag),
      .occupancy   (occupancy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [63:0] data;
      logic [2:0]  func;
      bit          rev;
      bit          ill;
      logic [3:0]  tag;
   } exp_t;

   typedef struct {
      logic [63:0] d;
      logic [2:0]  f;
      logic [63:0] ed;
      bit          er;
      bit          ei;
   } vec_t;

   // Expected conditioned request derived from the function-code semantics.
   function automatic exp_t model(input logic [63:0] d, input logic [2:0] f, input logic [3:0] t);
      exp_t        e;
      logic [63:0] r;
      logic [31:0] lo;
      lo = d[31:0];
      r = '0;
      case (f)
         3'b000: for (int i = 0; i < 64; i++) r[63-i] = d[i];
         3'b001, 3'b010: r = d;
         3'b100: begin
            r[63:32] = 32'hFFFF_FFFF;
            for (int i = 0; i < 32; i++) r[31-i] = lo[i];
         end
         3'b101: r = {32'hFFFF_FFFF, lo};
         3'b110: r = {32'h0, lo};
         default: r = '0;
      endcase
      e.data = r;
      e.func = f;
      e.rev  = (f == 3'b000) || (f == 3'b100);
      e.ill  = (f == 3'b011) || (f == 3'b111);
      e.tag  = t;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string n, input exp_t e);
      chk({n, ".data"}, out_data, e.data);
      chk({n, ".func"}, {61'h0, out_func}, {61'h0, e.func});
      chk({n, ".rev"}, {63'h0, out_revmode}, {63'h0, e.rev});
      chk({n, ".ill"}, {63'h0, out_illegal}, {63'h0, e.ill});
      chk({n, ".tag"}, {60'h0, out_tag}, {60'h0, e.tag});
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] d, input logic [2:0] f, input logic [3:0] t);
      in_valid = v;
      in_data  = d;
      in_func  = f;
      in_tag   = t;
   endtask

   initial begin
      vec_t tbl[10];
      exp_t q[$];
      exp_t last, e;
      bit   acc, pp;

      tbl[0] = '{64'h0000_0000_0000_0001, 3'b000, 64'h8000_0000_0000_0000, 1'b1, 1'b0};
      tbl[1] = '{64'hDEAD_BEEF_0000_0000, 3'b101, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b0};
      tbl[2] = '{64'hFFFF_FFFF_0000_00FF, 3'b110, 64'h0000_0000_0000_00FF, 1'b0, 1'b0};
      tbl[3] = '{64'h0000_0000_0000_1234, 3'b011, 64'h0,                   1'b0, 1'b1};
      tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 3'b111, 64'h0,                   1'b0, 1'b1};
      tbl[5] = '{64'h0123_4567_89AB_CDEF, 3'b001, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0};
      tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      tbl[7] = '{64'hAAAA_AAAA_0000_0001, 3'b100, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0};
      tbl[8] = '{64'h0000_0000_0000_00F0, 3'b000, 64'h0F00_0000_0000_0000, 1'b1, 1'b0};
      tbl[9] = '{64'h0000_0000_0000_0010, 3'b101, 64'hFFFF_FFFF_0000_0010, 1'b0, 1'b0};

      // Reset state while resetn is held low.
      #12;
      chk("rst.valid", {63'h0, out_valid}, 64'h0);
      chk("rst.ready", {63'h0, in_ready}, 64'h1);
      chk("rst.occ", {62'h0, occupancy}, 64'h0);
      chk_out("rst", '{64'h0, 3'b000, 1'b0, 1'b0, 4'h0});
      @(negedge clock);
      resetn = 1'b1;
      step();

      // Back-to-back table vectors with the core always ready: each appears one cycle after accept.
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, tbl[i].d, tbl[i].f, 4'(i));
         step();
         chk("tbl.valid", {63'h0, out_valid}, 64'h1);
         chk("tbl.occ", {62'h0, occupancy}, 64'h1);
         chk_out($sformatf("tbl%0d", i), '{tbl[i].ed, tbl[i].f, tbl[i].er, tbl[i].ei, 4'(i)});
      end
      in_valid = 1'b0;
      step();
      chk("idle.valid", {63'h0, out_valid}, 64'h0);
      chk("idle.occ", {62'h0, occupancy}, 64'h0);
      chk_out("idle.hold", '{tbl[9].ed, tbl[9].f, tbl[9].er, tbl[9].ei, 4'd9});

      // Fill to full with the core stalled, then drain and check order.
      out_ready = 1'b0;
      drive(1'b1, 64'd1, 3'b010, 4'd1);
      step();
      chk("full.occ1", {62'h0, occupancy}, 64'h1);
      chk("full.rdy1", {63'h0, in_ready}, 64'h1);
      drive(1'b1, 64'd2, 3'b010, 4'd2);
      step();
      chk("full.occ2", {62'h0, occupancy}, 64'h2);
      chk("full.rdy2", {63'h0, in_ready}, 64'h0);
      drive(1'b1, 64'd3, 3'b010, 4'd3);
      step();
      chk("full.occ3", {62'h0, occupancy}, 64'h2);
      chk("full.rdy3", {63'h0, in_ready}, 64'h0);
      chk("full.valid", {63'h0, out_valid}, 64'h1);
      chk_out("full.hold", model(64'd1, 3'b010, 4'd1));
      out_ready = 1'b1;
      step();
      chk("drain.occ1", {62'h0, occupancy}, 64'h1);
      chk("drain.rdy1", {63'h0, in_ready}, 64'h1);
      chk_out("drain.t2", model(64'd2, 3'b010, 4'd2));
      step();
      chk("drain.occ2", {62'h0, occupancy}, 64'h1);
      chk_out("drain.t3", model(64'd3, 3'b010, 4'd3));
      in_valid = 1'b0;
      step();
      chk("drain.valid", {63'h0, out_valid}, 64'h0);
      chk("drain.occ3", {62'h0, occupancy}, 64'h0);
      chk_out("drain.hold", model(64'd3, 3'b010, 4'd3));
      last = model(64'd3, 3'b010, 4'd3);

      // Random traffic against a queue model.
      for (int n = 0; n < 400; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = {$urandom, $urandom};
         if ($urandom_range(0, 4) == 0) in_data[31:0] = '0;
         in_func   = 3'($urandom_range(0, 7));
         in_tag    = 4'($urandom);
         acc = in_valid && (q.size() < DEPTH);
         pp  = (q.size() > 0) && out_ready;
         e   = model(in_data, in_func, in_tag);
         step();
         if (pp) last = q.pop_front();
         if (acc) q.push_back(e);
         chk("rnd.valid", {63'h0, out_valid}, (q.size() > 0) ? 64'h1 : 64'h0);
         chk("rnd.occ", {62'h0, occupancy}, 64'(q.size()));
         chk("rnd.ready", {63'h0, in_ready}, (q.size() < DEPTH) ? 64'h1 : 64'h0);
         if (q.size() > 0) chk_out("rnd", q[0]);
         else chk_out("rnd.hold", last);
      end

      // Asynchronous reset with two queued entries flushes everything at once.
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0;
      drive(1'b1, 64'hFFFF_0000_FFFF_0000, 3'b001, 4'hA);
      step();
      drive(1'b1, 64'h1234_5678_9ABC_DEF0, 3'b000, 4'hB);
      step();
      in_valid = 1'b0;
      chk("arst.pre_occ", {62'h0, occupancy}, 64'h2);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst.valid", {63'h0, out_valid}, 64'h0);
      chk("arst.occ", {62'h0, occupancy}, 64'h0);
      chk("arst.ready", {63'h0, in_ready}, 64'h1);
      chk_out("arst", '{64'h0, 3'b000, 1'b0, 1'b0, 4'h0});
      @(negedge clock);
      resetn = 1'b1;
      out_ready = 1'b1;
      step();
      chk("arst.after_valid", {63'h0, out_valid}, 64'h0);
      chk("arst.after_occ", {62'h0, occupancy}, 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
